// File: rtl/mips_run_dump_ctrl.sv
// mips_run_dump_ctrl
//
// Run-control and state-dump unit for the single-cycle MIPS core.
// After a start pulse it clock-enables the CPU until the PC reaches stop_pc
// (when STOP_MODE=1) or the cycle budget runs out. It then streams the final
// PC, every register-file entry and a window of data-memory words to a debug
// host through a valid/ready port.
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start after reset, CPU frozen
//   RUN      | CPU stepping, watching for stop_pc and the cycle budget
//   DUMP_PC  | presenting the final PC
//   DUMP_REG | presenting register file entry idx_q
//   DUMP_MEM | presenting data-memory word idx_q (relative to MEM_BASE)
//   DONE     | dump finished, done/timeout held until the next start
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           single-cycle pulse, honoured in IDLE or DONE only
//   stop_pc, pc     halt address and current CPU program counter
//   cpu_run         CPU clock-enable
//   rf_addr/rf_data register-file read port (combinational data)
//   dm_addr/dm_data data-memory read port (byte address, word aligned)
//   dump_*          valid/ready dump stream: kind, index, payload
//   busy, done      activity and completion status
//   timeout         halt caused by the cycle budget while STOP_MODE=1
module mips_run_dump_ctrl #(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 32,
    parameter int          NUM_REGS   = 32,
    parameter int unsigned MEM_BASE   = 0,
    parameter int          MEM_WORDS  = 2,
    parameter int          MAX_CYCLES = 1024,
    parameter int          STOP_MODE  = 1,
    localparam int         RF_AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] stop_pc,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpu_run,
    output logic [RF_AW-1:0]  rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [1:0]        dump_kind,
    output logic [15:0]       dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int              CNT_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [15:0]     REG_LAST = 16'(NUM_REGS - 1);
    localparam logic [15:0]     MEM_LAST = (MEM_WORDS > 0) ? 16'(MEM_WORDS - 1) : 16'd0;

    localparam logic [1:0] KIND_PC  = 2'd0;
    localparam logic [1:0] KIND_REG = 2'd1;
    localparam logic [1:0] KIND_MEM = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DUMP_PC,
        DUMP_REG,
        DUMP_MEM,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      idx_q, idx_d;
    logic             timeout_q, timeout_d;
    logic             pc_hit;

    // The stop compare is combinational so the instruction at stop_pc is
    // never clocked in.
    assign pc_hit = (STOP_MODE == 1) && (pc == stop_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        timeout_d  = timeout_q;
        cpu_run    = 1'b0;
        rf_addr    = '0;
        dm_addr    = '0;
        dump_valid = 1'b0;
        dump_kind  = KIND_PC;
        dump_index = '0;
        dump_data  = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    idx_d     = '0;
                    timeout_d = 1'b0;
                end
            end

            RUN: begin
                cpu_run = !pc_hit;
                if (pc_hit) begin
                    // PC match wins over a budget expiring in the same cycle.
                    state_d   = DUMP_PC;
                    idx_d     = '0;
                    timeout_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        // This last step still executes on the same edge.
                        state_d   = DUMP_PC;
                        idx_d     = '0;
                        timeout_d = (STOP_MODE == 1);
                    end
                end
            end

            DUMP_PC: begin
                dump_valid = 1'b1;
                dump_kind  = KIND_PC;
                // CPU is frozen here, so pc is stable for the whole stall.
                dump_data  = DATA_W'(pc);
                if (dump_ready) begin
                    state_d = DUMP_REG;
                    idx_d   = '0;
                end
            end

            DUMP_REG: begin
                dump_valid = 1'b1;
                dump_kind  = KIND_REG;
                dump_index = idx_q;
                rf_addr    = RF_AW'(idx_q);
                dump_data  = rf_data;
                if (dump_ready) begin
                    if (idx_q == REG_LAST) begin
                        idx_d   = '0;
                        state_d = (MEM_WORDS == 0) ? DONE : DUMP_MEM;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end

            DUMP_MEM: begin
                dump_valid = 1'b1;
                dump_kind  = KIND_MEM;
                dump_index = idx_q;
                dm_addr    = ADDR_W'(MEM_BASE) + ADDR_W'({idx_q, 2'b00});
                dump_data  = dm_data;
                if (dump_ready) begin
                    if (idx_q == MEM_LAST) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign done    = (state_q == DONE);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mips_run_dump_ctrl.sv
// Bench for mips_run_dump_ctrl. Two instances: A with default parameters,
// B with NUM_REGS=4, MEM_WORDS=0, MAX_CYCLES=16. Each has a small CPU model
// (PC stepping by 4 under cpu_run) and address-derived rf/dm read data.
module tb_mips_run_dump_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic dump_ready;

    logic        start_a, cpu_run_a, valid_a, busy_a, done_a, timeout_a;
    logic [31:0] stop_a, pc_a, rf_data_a, dm_addr_a, dm_data_a, data_a;
    logic [4:0]  rf_addr_a;
    logic [1:0]  kind_a;
    logic [15:0] index_a;

    logic        start_b, cpu_run_b, valid_b, busy_b, done_b, timeout_b;
    logic [31:0] stop_b, pc_b, rf_data_b, dm_addr_b, dm_data_b, data_b;
    logic [1:0]  rf_addr_b;
    logic [1:0]  kind_b;
    logic [15:0] index_b;

    mips_run_dump_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop_pc(stop_a), .pc(pc_a),
        .cpu_run(cpu_run_a), .rf_addr(rf_addr_a), .rf_data(rf_data_a),
        .dm_addr(dm_addr_a), .dm_data(dm_data_a), .dump_valid(valid_a),
        .dump_ready(dump_ready), .dump_kind(kind_a), .dump_index(index_a),
        .dump_data(data_a), .busy(busy_a), .done(done_a), .timeout(timeout_a)
    );

    mips_run_dump_ctrl #(.NUM_REGS(4), .MEM_WORDS(0), .MAX_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop_pc(stop_b), .pc(pc_b),
        .cpu_run(cpu_run_b), .rf_addr(rf_addr_b), .rf_data(rf_data_b),
        .dm_addr(dm_addr_b), .dm_data(dm_data_b), .dump_valid(valid_b),
        .dump_ready(dump_ready), .dump_kind(kind_b), .dump_index(index_b),
        .dump_data(data_b), .busy(busy_b), .done(done_b), .timeout(timeout_b)
    );

    // CPU models
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_a <= '0;
        else if (cpu_run_a) pc_a <= pc_a + 32'd4;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_b <= '0;
        else if (cpu_run_b) pc_b <= pc_b + 32'd4;
    end
    assign rf_data_a = 32'hA5A5_0000 | {27'b0, rf_addr_a};
    assign rf_data_b = 32'hB0B0_0000 | {30'b0, rf_addr_b};
    assign dm_data_a = 32'hD000_0000 ^ dm_addr_a;
    assign dm_data_b = 32'hDEAD_0000 ^ dm_addr_b;

    // Selected-instance view used by the shared tasks
    int          sel;
    logic        m_valid, m_run, m_busy, m_done, m_timeout;
    logic [1:0]  m_kind;
    logic [15:0] m_idx;
    logic [31:0] m_data, m_pc;
    always_comb begin
        if (sel == 0) begin
            m_valid = valid_a; m_run = cpu_run_a; m_busy = busy_a; m_done = done_a;
            m_timeout = timeout_a; m_kind = kind_a; m_idx = index_a; m_data = data_a;
            m_pc = pc_a;
        end else begin
            m_valid = valid_b; m_run = cpu_run_b; m_busy = busy_b; m_done = done_b;
            m_timeout = timeout_b; m_kind = kind_b; m_idx = index_b; m_data = data_b;
            m_pc = pc_b;
        end
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        rdy;
        logic [1:0]  kind;
        logic [15:0] idx;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    // One record per cycle: ready to drive and the word expected on the port.
    task automatic build_vecs(input int s, input logic [31:0] fpc, input bit bp);
        vec_t w[$];
        vec_t v;
        int   nreg, nmem, n, j;
        nreg = (s == 0) ? 32 : 4;
        nmem = (s == 0) ? 2 : 0;
        v.rdy = 1'b1; v.kind = 2'd0; v.idx = 16'd0; v.data = fpc;
        w.push_back(v);
        for (int r = 0; r < nreg; r++) begin
            v.kind = 2'd1; v.idx = 16'(r);
            v.data = ((s == 0) ? 32'hA5A5_0000 : 32'hB0B0_0000) | 32'(r);
            w.push_back(v);
        end
        for (int m = 0; m < nmem; m++) begin
            v.kind = 2'd2; v.idx = 16'(m);
            v.data = 32'hD000_0000 ^ 32'(4 * m);
            w.push_back(v);
        end
        vecs.delete();
        n = 0; j = 0;
        while (j < w.size()) begin
            v = w[j];
            v.rdy = bp ? (((n % 4) == 0) || ((n % 4) == 3)) : 1'b1;
            vecs.push_back(v);
            if (v.rdy) j++;
            n++;
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) start_a = v;
        else start_b = v;
    endtask

    // Called on a negedge with the instance idle/done. Returns after the
    // negedge where dump_valid is first seen.
    task automatic start_and_run(input int s, input int poke, output int runs,
                                 output bit stalled, output logic [31:0] stall_pc);
        bit got;
        runs = 0; stalled = 0; stall_pc = '0; got = 0;
        sel = s;
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        chk($sformatf("start%0d done_cleared", s), m_done, 0);
        chk($sformatf("start%0d timeout_cleared", s), m_timeout, 0);
        chk($sformatf("start%0d busy", s), m_busy, 1);
        for (int c = 0; c < 3000; c++) begin
            if (m_valid) begin
                got = 1;
                break;
            end
            if (m_run) runs++;
            else if (m_busy) begin
                stalled  = 1;
                stall_pc = m_pc;
            end
            set_start(s, (c == poke) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        set_start(s, 1'b0);
        chk($sformatf("start%0d reached_dump", s), got, 1);
    endtask

    task automatic check_stream(input int s, input bit chk_dm);
        bit dm_bad;
        dm_bad = 0;
        sel = s;
        for (int k = 0; k < vecs.size(); k++) begin
            chk($sformatf("stream%0d[%0d]", s, k), {m_valid, m_kind, m_idx, m_data},
                {1'b1, vecs[k].kind, vecs[k].idx, vecs[k].data});
            if (chk_dm && (dm_addr_b != 32'd0)) dm_bad = 1;
            dump_ready = vecs[k].rdy;
            @(negedge clk);
        end
        dump_ready = 1'b1;
        chk($sformatf("stream%0d done", s), m_done, 1);
        chk($sformatf("stream%0d idle_cpu", s), {m_busy, m_run, m_valid}, 3'b000);
        if (chk_dm) chk("dm_addr_b stays zero", dm_bad, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ctrl_a"}, {cpu_run_a, valid_a, kind_a, index_a, busy_a, done_a,
                               timeout_a, rf_addr_a}, '0);
        chk({tag, " data_a"}, {data_a, dm_addr_a}, '0);
        chk({tag, " ctrl_b"}, {cpu_run_b, valid_b, kind_b, index_b, busy_b, done_b,
                               timeout_b, rf_addr_b}, '0);
        chk({tag, " data_b"}, {data_b, dm_addr_b}, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int          runs;
        bit          stalled;
        logic [31:0] spc;
        bit          got;

        sel = 0; dump_ready = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        stop_a = 32'h20; stop_b = 32'hFFFF_FFF0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // A: PC-match halt at 0x20, full stream with ready high
        start_and_run(0, -1, runs, stalled, spc);
        chk("A run cycles", runs, 8);
        chk("A stall seen", stalled, 1);
        chk("A stall pc", spc, 32'h20);
        build_vecs(0, 32'h20, 0);
        check_stream(0, 0);
        chk("A timeout", timeout_a, 0);

        // A: restart from DONE, halt at 0x28, backpressure 1,0,0,1
        stop_a = 32'h28;
        start_and_run(0, -1, runs, stalled, spc);
        chk("A2 run cycles", runs, 2);
        build_vecs(0, 32'h28, 1);
        check_stream(0, 0);
        chk("A2 timeout", timeout_a, 0);

        // B: cycle budget halt, start poked mid-run
        start_and_run(1, 5, runs, stalled, spc);
        chk("B run cycles", runs, 16);
        chk("B no pc stall", stalled, 0);
        build_vecs(1, 32'h40, 0);
        check_stream(1, 1);
        chk("B timeout", timeout_b, 1);

        // B: start in DONE clears done/timeout, runs another full budget
        start_and_run(1, 3, runs, stalled, spc);
        chk("B2 run cycles", runs, 16);
        build_vecs(1, 32'h80, 0);
        check_stream(1, 1);
        chk("B2 timeout", timeout_b, 1);

        // A: reset in the middle of DUMP_MEM
        stop_a = 32'h30;
        start_and_run(0, -1, runs, stalled, spc);
        chk("A3 run cycles", runs, 2);
        got = 0;
        for (int c = 0; c < 200; c++) begin
            if (valid_a && (kind_a == 2'd2)) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("A3 reached mem dump", got, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // A: full rerun after reset
        stop_a = 32'h20;
        start_and_run(0, -1, runs, stalled, spc);
        chk("A4 run cycles", runs, 8);
        chk("A4 stall pc", spc, 32'h20);
        build_vecs(0, 32'h20, 0);
        check_stream(0, 0);
        chk("A4 timeout", timeout_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mips_run_dump_ctrl.md
Name: mips_run_dump_ctrl

Overview:
- Synthesizable run-control and state-dump unit for the single-cycle MIPS core.
- Gates CPU stepping after a start pulse and halts on one of two conditions: the PC reaching a programmable stop address, or a cycle budget expiring.
- After halting, it streams the final PC, every register-file entry and a parametrised window of data-memory words out through a valid/ready port.
- Sits between the CPU top level and a debug host, replacing fixed-delay end-of-program detection.

Parameters:
- DATA_W, 32, register/memory word width.
- ADDR_W, 32, PC and data-memory byte-address width.
- NUM_REGS, 32, register-file entries to dump, indices 0..NUM_REGS-1.
- MEM_BASE, 0, byte address of the first data-memory word dumped; must be a multiple of 4.
- MEM_WORDS, 2, number of 32-bit data-memory words dumped; 0 skips the memory phase.
- MAX_CYCLES, 1024, run-cycle budget; the counter width is clog2(MAX_CYCLES+1).
- STOP_MODE, 1, 0 = stop on cycle budget only; 1 = stop on PC match or cycle budget.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; honoured only in IDLE or DONE.
- stop_pc  in  ADDR_W  halt address; sampled every RUN cycle.
- pc  in  ADDR_W  current CPU ProgCounter value.
- cpu_run  out  1  CPU clock-enable; PC and register/memory writes advance only when this is 1.
- rf_addr  out  clog2(NUM_REGS)  register-file read address.
- rf_data  in  DATA_W  combinational register-file read data.
- dm_addr  out  ADDR_W  data-memory byte address, word aligned.
- dm_data  in  DATA_W  combinational big-endian word {M[a],M[a+1],M[a+2],M[a+3]}.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  host accepts the dump word.
- dump_kind  out  2  0 = final PC, 1 = register, 2 = memory word.
- dump_index  out  16  register index, or memory word index relative to MEM_BASE.
- dump_data  out  DATA_W  dump payload.
- busy  out  1  state is not IDLE or DONE.
- done  out  1  high in DONE.
- timeout  out  1  halt was caused by the cycle budget while STOP_MODE=1.

Behaviour:
- Reset values: state = IDLE, cycle counter = 0, index = 0, and every output = 0, including cpu_run, dump_valid, done, timeout, rf_addr and dm_addr.
- Reset is asynchronous and takes effect mid-run or mid-dump: CPU stepping stops immediately and there is no partial-dump recovery.
- States: IDLE, RUN, DUMP_PC, DUMP_REG, DUMP_MEM, DONE.
- IDLE/DONE, start=1 -> RUN on the next edge. On entry the cycle counter and timeout clear. The CPU PC is not touched by this block.
- RUN:
  - cpu_run = (STOP_MODE==1 && pc==stop_pc) ? 0 : 1, evaluated combinationally, so the instruction at stop_pc never executes.
  - The counter increments on each edge with cpu_run=1.
  - PC match -> DUMP_PC next edge, timeout=0.
  - counter == MAX_CYCLES-1 while cpu_run=1 -> that last step executes, then DUMP_PC, with timeout = STOP_MODE.
  - If both conditions hold in the same cycle, PC match wins: no step, timeout=0.
- DUMP_PC: dump_valid=1, kind 0, index 0, data = pc zero-extended or truncated to DATA_W.
- DUMP_REG: rf_addr = index, data = rf_data, kind 1.
- DUMP_MEM: dm_addr = MEM_BASE + 4*index, data = dm_data, kind 2.
- Handshake rules:
  - A word transfers on an edge where dump_valid && dump_ready.
  - kind, index and data are held stable while valid && !ready.
  - dump_valid never drops without a transfer.
  - One word transfers per cycle when ready is held high.
- Sequencing after each transfer:
  - DUMP_PC -> DUMP_REG with index 0.
  - DUMP_REG at index NUM_REGS-1 -> DUMP_MEM with index 0, or -> DONE if MEM_WORDS==0.
  - DUMP_MEM at index MEM_WORDS-1 -> DONE.
  - Otherwise index+1.
- Timing: cpu_run=0 in every state except RUN. Total dump = 1+NUM_REGS+MEM_WORDS transfers. With ready held high, done rises exactly that many cycles after leaving RUN.
- done and timeout hold in DONE until the next start or reset.
- start is ignored in RUN and in all DUMP states.

Test Plan:
- Default params, stop_pc=0x20, pc stepping by 4 from 0, ready=1 -> cpu_run high for 8 cycles and low while pc=0x20. Stream: kind0 0x00000020, then regs 0..31, then mem words 0..1. done after 35 transfers, timeout=0.
- STOP_MODE=1, MAX_CYCLES=16, stop_pc never reached -> exactly 16 cpu_run cycles, timeout=1, final PC dumped = 0x40.
- Backpressure: ready toggles 1,0,0,1 during DUMP_REG -> index and data stable across stall cycles, no word lost or duplicated, reg 5 = rf[5].
- MEM_WORDS=0, NUM_REGS=4 -> stream is PC, reg0..reg3, then DONE. dm_addr stays 0.
- rst_n low in the middle of DUMP_MEM -> all outputs 0 immediately. A later start reruns the full sequence with the counter cleared.
- start pulsed during RUN -> ignored, cycle count unchanged. start in DONE -> new RUN, done and timeout clear.
